// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. Produces the load
//   enables and bubble/NOP controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. It handles:
//     - load-use stalls
//     - taken branch/jump flushes
//     - multi-cycle MULT/DIV occupancy of EX
//     - external memory-wait freeze
//   State and the MDU down-counter are registered. Every control output is
//   combinational from the state plus the current inputs.
//
//   Optional: define HAZARD_PERF_CNT_EN to add the stall-cycle and flush
//   performance counters (o_StallCycles, o_FlushCount).
//
// Ports
//   i_Clk            rising-edge clock
//   i_Reset          synchronous reset, active-high
//   i_IDRs/i_IDRt    rs/rt fields of the instruction in ID
//   i_IDMduStart     instruction in ID is MULT/MULTU/DIV/DIVU
//   i_EXMemRead      instruction in EX is a load
//   i_EXRegDst       destination register of the instruction in EX
//   i_EXBranchTaken  branch/jump resolved taken in EX
//   i_ExtStall       memory not ready; freeze the whole pipeline
//   o_*Write         pipeline register load enables
//   o_IFIDFlush      IF/ID loads a NOP this edge
//   o_IDEXFlush      ID/EX loads a bubble this edge
//   o_MduBusy        MDU occupying EX
//   o_StallCycles    (HAZARD_PERF_CNT_EN) cycles with PC frozen, outside reset
//   o_FlushCount     (HAZARD_PERF_CNT_EN) number of taken-branch flushes
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 32
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [4:0]       i_IDRs,
    input  logic [4:0]       i_IDRt,
    input  logic             i_IDMduStart,
    input  logic             i_EXMemRead,
    input  logic [4:0]       i_EXRegDst,
    input  logic             i_EXBranchTaken,
    input  logic             i_ExtStall,
    output logic             o_PCWrite,
    output logic             o_IFIDWrite,
    output logic             o_IDEXWrite,
    output logic             o_EXMEMWrite,
    output logic             o_MEMWBWrite,
    output logic             o_IFIDFlush,
    output logic             o_IDEXFlush,
    output logic             o_MduBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_StallCycles,
    output logic [CNT_W-1:0] o_FlushCount
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    // Counter preload on MDU start. The start cycle itself counts as the first
    // EX cycle, so the front end stalls for MDU_LATENCY-1 cycles.
    localparam logic [7:0] LP_MDU_LOAD = 8'(MDU_LATENCY - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_mdu_cnt;
    logic [7:0] w_mdu_cnt_nxt;
    logic       w_load_use;
    logic       w_branch_flush;

    // $zero is never a real producer, so it can never cause a stall.
    assign w_load_use = i_EXMemRead && (i_EXRegDst != 5'd0) &&
                        ((i_EXRegDst == i_IDRs) || (i_EXRegDst == i_IDRt));

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state   <= RUN;
            r_mdu_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mdu_cnt <= w_mdu_cnt_nxt;
        end
    end

    always_comb begin
        o_PCWrite      = 1'b0;
        o_IFIDWrite    = 1'b0;
        o_IDEXWrite    = 1'b0;
        o_EXMEMWrite   = 1'b0;
        o_MEMWBWrite   = 1'b0;
        o_IFIDFlush    = 1'b0;
        o_IDEXFlush    = 1'b0;
        o_MduBusy      = 1'b0;
        w_branch_flush = 1'b0;
        w_state_nxt    = r_state;
        w_mdu_cnt_nxt  = r_mdu_cnt;

        if (i_Reset) begin
            // Hold every register and load NOP/bubble into IF/ID and ID/EX.
            o_IFIDFlush = 1'b1;
            o_IDEXFlush = 1'b1;
        end else if (i_ExtStall) begin
            // Full freeze: nothing moves and state/counter hold. The MDU op
            // still sits in EX, so busy stays visible while frozen.
            o_MduBusy = (r_state == MDU_BUSY);
        end else begin
            unique case (r_state)
                RUN: begin
                    o_PCWrite    = 1'b1;
                    o_IFIDWrite  = 1'b1;
                    o_IDEXWrite  = 1'b1;
                    o_EXMEMWrite = 1'b1;
                    o_MEMWBWrite = 1'b1;
                    if (i_EXBranchTaken) begin
                        // Kill the two wrong-path instructions in IF and ID.
                        o_IFIDFlush    = 1'b1;
                        o_IDEXFlush    = 1'b1;
                        w_branch_flush = 1'b1;
                    end else if (w_load_use) begin
                        o_PCWrite   = 1'b0;
                        o_IFIDWrite = 1'b0;
                        o_IDEXFlush = 1'b1;
                    end else if (i_IDMduStart) begin
                        w_state_nxt   = MDU_BUSY;
                        w_mdu_cnt_nxt = LP_MDU_LOAD;
                    end
                end
                MDU_BUSY: begin
                    // The MDU op is held in ID/EX. The back end drains, and the
                    // datapath turns EX/MEM into a bubble using o_MduBusy.
                    o_MduBusy     = 1'b1;
                    o_EXMEMWrite  = 1'b1;
                    o_MEMWBWrite  = 1'b1;
                    w_mdu_cnt_nxt = r_mdu_cnt - 8'd1;
                    if (r_mdu_cnt == 8'd1) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            // Any cycle with the PC frozen counts, including external freezes.
            if (!o_PCWrite) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_branch_flush) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign o_StallCycles = r_stall_cycles;
    assign o_FlushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    // Output vector layout:
    //   {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
    //    IFIDFlush, IDEXFlush, MduBusy}
    localparam logic [7:0] V_RST   = 8'b00000_110;
    localparam logic [7:0] V_RUN   = 8'b11111_000;
    localparam logic [7:0] V_LU    = 8'b00111_010;
    localparam logic [7:0] V_BR    = 8'b11111_110;
    localparam logic [7:0] V_BUSY  = 8'b00011_001;
    localparam logic [7:0] V_FRZ   = 8'b00000_000;
    localparam logic [7:0] V_FRZMD = 8'b00000_001;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_mdu;
    logic       ex_mrd;
    logic [4:0] ex_dst;
    logic       ex_br;
    logic       ext_stall;
    logic       pcw;
    logic       ifidw;
    logic       idexw;
    logic       exmemw;
    logic       memwbw;
    logic       ifidf;
    logic       idexf;
    logic       busy;
    logic [7:0] outs;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cyc;
    logic [31:0] flush_cnt;
`endif

    int n_chk;
    int n_fail;

    pipeline_hazard_ctrl #(
        .MDU_LATENCY(LAT)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_IDRs         (id_rs),
        .i_IDRt         (id_rt),
        .i_IDMduStart   (id_mdu),
        .i_EXMemRead    (ex_mrd),
        .i_EXRegDst     (ex_dst),
        .i_EXBranchTaken(ex_br),
        .i_ExtStall     (ext_stall),
        .o_PCWrite      (pcw),
        .o_IFIDWrite    (ifidw),
        .o_IDEXWrite    (idexw),
        .o_EXMEMWrite   (exmemw),
        .o_MEMWBWrite   (memwbw),
        .o_IFIDFlush    (ifidf),
        .o_IDEXFlush    (idexf),
        .o_MduBusy      (busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_StallCycles  (stall_cyc),
        .o_FlushCount   (flush_cnt)
`endif
    );

    assign outs = {pcw, ifidw, idexw, exmemw, memwbw, ifidf, idexf, busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Sample the combinational outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst       = 1'b0;
        id_rs     = 5'd1;
        id_rt     = 5'd2;
        id_mdu    = 1'b0;
        ex_mrd    = 1'b0;
        ex_dst    = 5'd3;
        ex_br     = 1'b0;
        ext_stall = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();

        // Reset behaviour and release
        rst = 1'b1;
        cyc("rst0", V_RST);
        cyc("rst1", V_RST);
        idle();
        cyc("run_after_rst", V_RUN);

        // Load-use on rs: the stall lasts exactly one cycle
        ex_mrd = 1'b1;
        ex_dst = 5'd8;
        id_rs  = 5'd8;
        cyc("lu_rs", V_LU);
        idle();
        cyc("lu_rs_clear", V_RUN);

        // Load-use on rt
        ex_mrd = 1'b1;
        ex_dst = 5'd9;
        id_rt  = 5'd9;
        cyc("lu_rt", V_LU);

        // A load into $zero never stalls
        idle();
        ex_mrd = 1'b1;
        ex_dst = 5'd0;
        id_rs  = 5'd0;
        cyc("lu_zero", V_RUN);

        // Register match without a load does not stall
        idle();
        ex_dst = 5'd8;
        id_rs  = 5'd8;
        cyc("nolu_match", V_RUN);

        // Branch beats load-use and MDU start
        ex_mrd = 1'b1;
        ex_br  = 1'b1;
        id_mdu = 1'b1;
        cyc("br_over_lu", V_BR);
        idle();
        cyc("br_no_mdu", V_RUN);

        // Load-use beats MDU start
        ex_mrd = 1'b1;
        ex_dst = 5'd8;
        id_rs  = 5'd8;
        id_mdu = 1'b1;
        cyc("lu_over_mdu", V_LU);
        idle();
        cyc("lu_no_mdu", V_RUN);

        // MDU with LAT=4: start cycle, three busy cycles, then back to RUN.
        // Hazards raised while busy are ignored.
        id_mdu = 1'b1;
        cyc("mdu_start", V_RUN);
        idle();
        cyc("mdu_b1", V_BUSY);
        ex_br = 1'b1;
        cyc("mdu_b2_br", V_BUSY);
        ex_br  = 1'b0;
        ex_mrd = 1'b1;
        ex_dst = 5'd8;
        id_rs  = 5'd8;
        cyc("mdu_b3_lu", V_BUSY);
        idle();
        cyc("mdu_done", V_RUN);

        // Back-to-back MDU ops with start held high: no overlap
        id_mdu = 1'b1;
        cyc("bb_start1", V_RUN);
        cyc("bb_b1", V_BUSY);
        cyc("bb_b2", V_BUSY);
        cyc("bb_b3", V_BUSY);
        cyc("bb_start2", V_RUN);
        id_mdu = 1'b0;
        cyc("bb2_b1", V_BUSY);
        cyc("bb2_b2", V_BUSY);
        cyc("bb2_b3", V_BUSY);
        cyc("bb2_done", V_RUN);

        // Freeze mid-MDU: the counter holds, so three busy cycles in total
        id_mdu = 1'b1;
        cyc("frz_start", V_RUN);
        id_mdu = 1'b0;
        cyc("frz_b1", V_BUSY);
        ext_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc("frz_hold", V_FRZMD);
        end
        ext_stall = 1'b0;
        cyc("frz_b2", V_BUSY);
        cyc("frz_b3", V_BUSY);
        cyc("frz_done", V_RUN);

        // Freeze in RUN suppresses a branch flush
        ext_stall = 1'b1;
        ex_br     = 1'b1;
        cyc("frz_run_br", V_FRZ);
        idle();
        cyc("frz_run_after", V_RUN);

        // Reset during MDU abandons the operation
        id_mdu = 1'b1;
        cyc("rstmdu_start", V_RUN);
        id_mdu = 1'b0;
        cyc("rstmdu_b1", V_BUSY);
        rst = 1'b1;
        cyc("rstmdu_rst", V_RST);
        idle();
        cyc("rstmdu_run", V_RUN);

`ifdef HAZARD_PERF_CNT_EN
        // Counters: one load-use stall, one branch, one MDU op (3 stalls)
        chk("cnt_stall_rst", stall_cyc, 32'd0);
        chk("cnt_flush_rst", flush_cnt, 32'd0);
        ex_mrd = 1'b1;
        ex_dst = 5'd8;
        id_rs  = 5'd8;
        cyc("cnt_lu", V_LU);
        idle();
        ex_br = 1'b1;
        cyc("cnt_br", V_BR);
        idle();
        id_mdu = 1'b1;
        cyc("cnt_mdu", V_RUN);
        idle();
        cyc("cnt_b1", V_BUSY);
        cyc("cnt_b2", V_BUSY);
        cyc("cnt_b3", V_BUSY);
        @(negedge clk);
        chk("cnt_stall", stall_cyc, 32'd4);
        chk("cnt_flush", flush_cnt, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
